pkmc_bankrow_tracker: RTL
=========================

Name: pkmc_bankrow_tracker

Overview:
- Multi-bank open-row tracker for the pkmc SDRAM memory controller.
- Keeps one open-row register plus a valid bit per SDRAM bank, and classifies each incoming access as row HIT, row MISS (other row open) or bank EMPTY.
- Runs a per-bank idle timer and requests a precharge of banks left open too long.
- Sits between the pkmc address decoder and the command sequencer FSM.

Parameters:
- NBANKS, 4, number of SDRAM banks tracked (power of two, 2..8)
- BANKW, 2, bank index width, equals log2(NBANKS)
- ROWW, 13, row address width (matches `ROWLEN)
- IDLE_MAX, 255, idle cycles before a close request; 0 disables timers
- IDLEW, 8, idle counter width, must hold IDLE_MAX

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- q_bank  in  BANKW  bank of the access being classified
- q_row  in  ROWW  row of the access being classified
- q_hit  out  1  bank open and open row == q_row (combinational)
- q_miss  out  1  bank open and open row != q_row (combinational)
- q_empty  out  1  bank closed (combinational)
- act_en  in  1  ACTIVATE issued: open q_bank with row q_row
- pre_en  in  1  PRECHARGE issued to bank pre_bank
- pre_bank  in  BANKW  bank closed by pre_en
- pre_all  in  1  PRECHARGE-ALL or AUTO-REFRESH issued: close every bank
- acc_en  in  1  READ/WRITE issued to q_bank (restarts its idle timer)
- close_req  out  1  some open bank reached IDLE_MAX
- close_bank  out  BANKW  lowest-index bank requesting close
- open_mask  out  NBANKS  registered valid bits, bit i = bank i open

Behaviour:
- Reset (rst=1 at clk edge):
  - all valid bits 0, all row registers 0, all idle counters 0.
  - Outputs then: open_mask=0, close_req=0, close_bank=0, q_empty=1, q_hit=0, q_miss=0.
  - rst overrides every other input in the same cycle.
- Classification:
  - Purely combinational from the current state and q_bank/q_row, so zero latency.
  - Exactly one of q_hit/q_miss/q_empty is high at all times.
- Updates take effect at the clk edge; queries reflect them from the next cycle. Per bank b, priority highest first:
  1. pre_all: valid[b]<=0, counter<=0.
  2. act_en and q_bank==b: valid<=1, row<=q_row, counter<=0. Re-activating an already open bank is legal and overwrites the row; no error flag.
  3. pre_en and pre_bank==b: valid<=0, counter<=0.
  4. acc_en and q_bank==b and valid: counter<=0. acc_en to a closed bank is ignored.
  5. Otherwise, valid and counter<IDLE_MAX: counter<=counter+1. The counter saturates at IDLE_MAX and never wraps.
- Simultaneous events: act_en and pre_en on different banks are both applied. When they hit the same bank, act_en wins.
- Idle close:
  - Bank b requests close when valid[b] and counter[b]==IDLE_MAX.
  - close_req is the OR over banks; close_bank is a priority encode of the lowest requesting index.
  - close_req/close_bank are driven from registered state, so there is no combinational path from inputs.
  - The request holds until the bank is precharged or accessed.
  - With IDLE_MAX=0, close_req is tied 0 and counters stay 0.
- row registers keep their stale value after close; they are only meaningful while valid.
- open_mask is driven directly from the valid register.

Decomposition:
- Shared package/include (pkmc_memctrl_defines): bank/row width constants, and the encodings PKMC_ROW_HIT/MISS/EMPTY if the sequencer wants a 2-bit status.
- One natural sub-module: pkmc_bank_entry, holding one bank's valid, row and idle counter with its priority logic. It is instantiated NBANKS times by a generate loop.
- Top level holds the query mux, close_req OR and priority encoder.

Test Plan:
- Reset then query bank 2 row 0x0A5 -> q_empty=1, open_mask=4'b0000, close_req=0.
- act_en bank1 row 0x123; next cycle query bank1 row 0x123 -> q_hit=1; query bank1 row 0x124 -> q_miss=1; open_mask=4'b0010.
- Open banks 0 and 3, then pre_en bank0 and act_en bank3 row 0x7 in the same cycle -> open_mask=4'b1000, bank3 hits row 0x7. Repeat with act_en and pre_en on the same bank -> bank stays open with the new row.
- IDLE_MAX=4, open bank2, no access -> close_req=1, close_bank=2 exactly 4 cycles after activation. acc_en to bank2 -> close_req drops the next cycle. Open bank1 idle as well -> close_bank=1 (lowest index first).
- Banks 0..3 open, pre_all asserted together with act_en bank1 -> open_mask=4'b0000, all queries q_empty.
- rst asserted mid-operation with act_en also high -> all banks closed on the next cycle, counters 0, close_req=0.

Source files
------------

// File: rtl/pkmc_bankrow_tracker_pkg.sv
// -----------------------------------------------------------------------------
// pkmc_bankrow_tracker_pkg
//   Shared constants and types for the pkmc open-row tracker.
//   - Default bank/row/idle-timer geometry of the pkmc SDRAM controller.
//   - 2-bit row status encoding for consumers that prefer a coded status
//     over the three one-hot q_hit/q_miss/q_empty flags.
//   - pkmc_classify(): maps (bank open, row matches) onto that encoding.
// -----------------------------------------------------------------------------
package pkmc_bankrow_tracker_pkg;

  localparam int PKMC_NBANKS   = 4;
  localparam int PKMC_BANKW    = 2;
  localparam int PKMC_ROWW     = 13;
  localparam int PKMC_IDLE_MAX = 255;
  localparam int PKMC_IDLEW    = 8;

  typedef enum logic [1:0] {
    PKMC_ROW_EMPTY = 2'd0,
    PKMC_ROW_HIT   = 2'd1,
    PKMC_ROW_MISS  = 2'd2
  } pkmc_row_status_e;

  function automatic pkmc_row_status_e pkmc_classify(input logic valid,
                                                     input logic row_match);
    if (!valid) begin
      return PKMC_ROW_EMPTY;
    end else if (row_match) begin
      return PKMC_ROW_HIT;
    end else begin
      return PKMC_ROW_MISS;
    end
  endfunction

endpackage

// File: rtl/pkmc_bankrow_tracker_if.sv
// -----------------------------------------------------------------------------
// pkmc_bankrow_tracker_if
//   Bundle between the address decoder / command sequencer (master) and the
//   open-row tracker (slave).
//   Query   : q_bank, q_row  -> q_hit, q_miss, q_empty (combinational)
//   Commands: act_en, pre_en/pre_bank, pre_all, acc_en
//   Status  : close_req, close_bank, open_mask (from registered state)
// -----------------------------------------------------------------------------
interface pkmc_bankrow_tracker_if
  import pkmc_bankrow_tracker_pkg::*;
#(
  parameter int NBANKS = PKMC_NBANKS,
  parameter int BANKW  = PKMC_BANKW,
  parameter int ROWW   = PKMC_ROWW
);

  logic [BANKW-1:0]  q_bank;
  logic [ROWW-1:0]   q_row;
  logic              q_hit;
  logic              q_miss;
  logic              q_empty;
  logic              act_en;
  logic              pre_en;
  logic [BANKW-1:0]  pre_bank;
  logic              pre_all;
  logic              acc_en;
  logic              close_req;
  logic [BANKW-1:0]  close_bank;
  logic [NBANKS-1:0] open_mask;

  modport master (
    output q_bank, q_row, act_en, pre_en, pre_bank, pre_all, acc_en,
    input  q_hit, q_miss, q_empty, close_req, close_bank, open_mask
  );

  modport slave (
    input  q_bank, q_row, act_en, pre_en, pre_bank, pre_all, acc_en,
    output q_hit, q_miss, q_empty, close_req, close_bank, open_mask
  );

endinterface

// File: rtl/pkmc_bankrow_tracker_bank_entry.sv
// -----------------------------------------------------------------------------
// pkmc_bankrow_tracker_bank_entry
//   State of a single SDRAM bank: open flag, open row and idle counter.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     i_pre_all    : close this bank (precharge-all / auto-refresh)
//     i_act, i_row : activate this bank with row i_row
//     i_pre        : precharge this bank
//     i_acc        : read/write to this bank, restarts the idle counter
//     o_valid      : bank open
//     o_row        : open row (stale while closed)
//     o_close      : bank open and idle for IDLE_MAX cycles
// -----------------------------------------------------------------------------
module pkmc_bankrow_tracker_bank_entry
  import pkmc_bankrow_tracker_pkg::*;
#(
  parameter int ROWW     = PKMC_ROWW,
  parameter int IDLE_MAX = PKMC_IDLE_MAX,
  parameter int IDLEW    = PKMC_IDLEW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pre_all,
  input  logic            i_act,
  input  logic            i_pre,
  input  logic            i_acc,
  input  logic [ROWW-1:0] i_row,
  output logic            o_valid,
  output logic [ROWW-1:0] o_row,
  output logic            o_close
);

  localparam logic [IDLEW-1:0] LP_IDLE_MAX = IDLEW'(IDLE_MAX);

  logic             r_valid;
  logic [ROWW-1:0]  r_row;
  logic [IDLEW-1:0] r_cnt;

  // Branch order is the command priority: a same-bank activate beats a
  // precharge, and only pre_all beats an activate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_row   <= '0;
      r_cnt   <= '0;
    end else if (i_pre_all) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_act) begin
      r_valid <= 1'b1;
      r_row   <= i_row;
      r_cnt   <= '0;
    end else if (i_pre) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_acc && r_valid) begin
      r_cnt   <= '0;
    end else if (r_valid && (r_cnt < LP_IDLE_MAX)) begin
      // Saturates at IDLE_MAX so a pending close request is held.
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_row   = r_row;

  generate
    if (IDLE_MAX == 0) begin : g_no_timer
      assign o_close = 1'b0;
    end else begin : g_timer
      assign o_close = r_valid && (r_cnt == LP_IDLE_MAX);
    end
  endgenerate

endmodule

// File: rtl/pkmc_bankrow_tracker.sv
// -----------------------------------------------------------------------------
// pkmc_bankrow_tracker
//   Multi-bank open-row tracker: classifies each access as row hit, row miss
//   or bank empty and asks for a precharge of banks left idle too long.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : pkmc_bankrow_tracker_if.slave (query, commands, status)
// -----------------------------------------------------------------------------
module pkmc_bankrow_tracker
  import pkmc_bankrow_tracker_pkg::*;
#(
  parameter int NBANKS   = PKMC_NBANKS,
  parameter int BANKW    = PKMC_BANKW,
  parameter int ROWW     = PKMC_ROWW,
  parameter int IDLE_MAX = PKMC_IDLE_MAX,
  parameter int IDLEW    = PKMC_IDLEW
) (
  input logic                   clk,
  input logic                   rst,
  pkmc_bankrow_tracker_if.slave bus
);

  logic [NBANKS-1:0] w_valid;
  logic [NBANKS-1:0] w_close;
  logic [NBANKS-1:0] w_act;
  logic [NBANKS-1:0] w_pre;
  logic [NBANKS-1:0] w_acc;
  logic [ROWW-1:0]   w_row [NBANKS];
  logic [BANKW-1:0]  w_close_bank;
  pkmc_row_status_e  w_status;

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      assign w_act[gi] = bus.act_en && (bus.q_bank == BANKW'(gi));
      assign w_pre[gi] = bus.pre_en && (bus.pre_bank == BANKW'(gi));
      assign w_acc[gi] = bus.acc_en && (bus.q_bank == BANKW'(gi));

      pkmc_bankrow_tracker_bank_entry #(
        .ROWW     (ROWW),
        .IDLE_MAX (IDLE_MAX),
        .IDLEW    (IDLEW)
      ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .i_pre_all (bus.pre_all),
        .i_act     (w_act[gi]),
        .i_pre     (w_pre[gi]),
        .i_acc     (w_acc[gi]),
        .i_row     (bus.q_row),
        .o_valid   (w_valid[gi]),
        .o_row     (w_row[gi]),
        .o_close   (w_close[gi])
      );
    end
  endgenerate

  // Zero-latency query against the selected bank's current state.
  assign w_status = pkmc_classify(w_valid[bus.q_bank],
                                  w_row[bus.q_bank] == bus.q_row);

  assign bus.q_hit   = (w_status == PKMC_ROW_HIT);
  assign bus.q_miss  = (w_status == PKMC_ROW_MISS);
  assign bus.q_empty = (w_status == PKMC_ROW_EMPTY);

  // Scan from the top so the lowest requesting bank is the last one written.
  always_comb begin
    w_close_bank = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (w_close[i]) begin
        w_close_bank = BANKW'(i);
      end
    end
  end

  assign bus.close_req  = |w_close;
  assign bus.close_bank = w_close_bank;
  assign bus.open_mask  = w_valid;

endmodule
